// File: rtl/r200dmem_resp_if.sv
// Request/response bus between a CPU load/store unit and the r200dmem_resp data memory.
// master is the CPU side, slave is the responder side.
interface r200dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_func3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_func3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/r200dmem_resp.sv
// Single-port RV32I data memory with a wait-stated valid/ready request/response protocol.
// Optional R200_DMEM_ALIGN_CHK_EN flags misaligned/illegal accesses instead of aligning them.
module r200dmem_resp #(
  parameter int unsigned WAIT_CYC = 1,
  parameter int unsigned ADDR_W   = 10
) (
  input logic            clk,
  input logic            rst_n,
  r200dmem_resp_if.slave bus
);
  localparam int unsigned Depth    = 1 << ADDR_W;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        func3_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q;

  logic              in_idle, accept, enter_resp, mem_we;
  logic              acc_wr;
  logic [ADDR_W+1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [2:0]        acc_func3;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off, eff_off;
  size_e             size;
  logic              is_unsigned, illegal, acc_err;
  logic [3:0]        be;
  logic [31:0]       wrep, rd_word, ld_data;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       mem_q [Depth];

  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYC == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and strobes
  always_comb begin
    in_idle       = (state_q == StIdle);
    bus.req_ready = in_idle;
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    accept        = bus.req_valid & in_idle;
    enter_resp    = (state_d == StResp) && (state_q != StResp);
    mem_we        = enter_resp & acc_wr & ~acc_err;
  end

  // With WAIT_CYC=0 the access completes on the acceptance edge, so use the live request.
  assign acc_wr    = in_idle ? bus.req_wr               : wr_q;
  assign acc_addr  = in_idle ? bus.req_addr[ADDR_W+1:0] : addr_q;
  assign acc_wdata = in_idle ? bus.req_wdata            : wdata_q;
  assign acc_func3 = in_idle ? bus.req_func3            : func3_q;
  assign idx       = acc_addr[ADDR_W+1:2];
  assign off       = acc_addr[1:0];

  always_comb begin
    size        = SzWord;
    is_unsigned = 1'b0;
    illegal     = 1'b0;
    if (acc_wr) begin
      case (acc_func3)
        3'b000:  size = SzByte;
        3'b001:  size = SzHalf;
        3'b010:  size = SzWord;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (acc_func3)
        3'b000:  size = SzByte;
        3'b001:  size = SzHalf;
        3'b010:  size = SzWord;
        3'b100:  begin size = SzByte; is_unsigned = 1'b1; end
        3'b101:  begin size = SzHalf; is_unsigned = 1'b1; end
        default: illegal = 1'b1;
      endcase
    end
  end

`ifdef R200_DMEM_ALIGN_CHK_EN
  logic misalign;
  assign misalign = ((size == SzHalf) && off[0]) || ((size == SzWord) && (off != 2'b00));
  assign acc_err  = illegal | misalign;
  assign eff_off  = off;
`else
  // Illegal codes fall back to word size above; offending offset bits are dropped.
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign acc_err        = 1'b0;
  always_comb begin
    case (size)
      SzByte:  eff_off = off;
      SzHalf:  eff_off = {off[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end
`endif

  always_comb begin
    case (size)
      SzByte: begin
        be   = 4'b0001 << eff_off;
        wrep = {4{acc_wdata[7:0]}};
      end
      SzHalf: begin
        be   = eff_off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{acc_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = acc_wdata;
      end
    endcase
  end

  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[{eff_off, 3'b000} +: 8];
  assign rd_half = eff_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (size)
      SzByte:  ld_data = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SzHalf:  ld_data = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase
    rdata_d = (acc_wr | acc_err) ? 32'd0 : ld_data;
  end

  // Request capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      func3_q <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr[ADDR_W+1:0];
        wdata_q <= bus.req_wdata;
        func3_q <= bus.req_func3;
      end
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= acc_err;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_r200dmem_resp.sv
// Scoreboard bench for r200dmem_resp: directed and random accesses checked against a
// byte-level memory model; a second instance with WAIT_CYC=3 covers reset abort.
module tb_r200dmem_resp;
  localparam int unsigned AW     = 10;
  localparam int unsigned WORDS  = 1 << AW;
  localparam int unsigned WAIT_M = 1;
  localparam int unsigned WAIT_B = 3;

  logic clk = 1'b0;
  logic rst_n, rst_n_b;
  always #5 clk = ~clk;

  r200dmem_resp_if m ();
  r200dmem_resp_if b ();

  r200dmem_resp #(.WAIT_CYC(WAIT_M), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
  r200dmem_resp #(.WAIT_CYC(WAIT_B), .ADDR_W(AW)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(b));

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] acc;
    logic [7:0]  hold;
    logic [15:0] id;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned op_id   = 0;
  logic [31:0] model_mem [WORDS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    n_tests++;
    if (got !== need) begin
      n_fail++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  // Reference: byte-addressed memory, size/sign from funct3, natural alignment or error.
  function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int unsigned idx, off, size;
    logic        ill, sgn;
    logic [31:0] w, mask;
    idx  = (addr / 4) % WORDS;
    off  = addr % 4;
    size = 4; ill = 1'b0; sgn = 1'b0; rd = 32'd0; err = 1'b0;
    if (wr) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: ill = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: ill = 1'b1;
      endcase
    end
`ifdef R200_DMEM_ALIGN_CHK_EN
    if (ill || (off % size) != 0) begin
      err = 1'b1;
      return;
    end
`else
    if (ill) size = 4;
    off = off - (off % size);
`endif
    w = model_mem[idx];
    if (wr) begin
      for (int k = 0; k < int'(size); k++) w[8*(int'(off)+k) +: 8] = wdata[8*k +: 8];
      model_mem[idx] = w;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
      rd   = (w >> (8*off)) & mask;
      if (sgn && size < 4 && rd[8*size-1]) rd = rd | ~mask;
    end
  endfunction

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input int hold);
    exp_t e;
    int   guard;
    @(negedge clk);
    m.req_valid = 1'b1; m.req_wr = wr; m.req_addr = addr; m.req_wdata = wdata; m.req_func3 = f3;
    guard = 0;
    while (m.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (m.req_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL req_op%0d: req_ready stuck at %b, need 1", op_id, m.req_ready);
      m.req_valid = 1'b0;
      op_id++;
      return;
    end
    model(wr, addr, wdata, f3, e.rdata, e.err);
    e.acc  = cyc;
    e.hold = 8'(hold);
    e.id   = 16'(op_id);
    sb.push_back(e);
    op_id++;
    @(posedge clk);
    #1;
    m.req_valid = 1'b0; m.req_wr = 1'($urandom); m.req_addr = $urandom;
    m.req_wdata = $urandom; m.req_func3 = 3'($urandom);
  endtask

  // Monitor: pops on the first valid cycle, then checks hold stability and drives rsp_ready.
  logic        busy = 1'b0;
  exp_t        cur;
  int          hold_left = 0;
  logic [31:0] seen_rd;
  logic        seen_err;

  always @(negedge clk) begin
    if (m.rsp_valid === 1'b1) begin
      n_tests++;
      if (!busy) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h, need no response", m.rsp_rdata);
        end else begin
          cur       = sb.pop_front();
          busy      = 1'b1;
          hold_left = int'(cur.hold);
          seen_rd   = m.rsp_rdata;
          seen_err  = m.rsp_err;
          if (m.rsp_rdata !== cur.rdata || m.rsp_err !== cur.err ||
              cyc != cur.acc + WAIT_M + 1) begin
            n_fail++;
            $display("FAIL rsp_op%0d: rdata=%h err=%b cycle=%0d, need rdata=%h err=%b cycle=%0d",
                     cur.id, m.rsp_rdata, m.rsp_err, cyc, cur.rdata, cur.err,
                     cur.acc + WAIT_M + 1);
          end
        end
      end else if (m.rsp_rdata !== seen_rd || m.rsp_err !== seen_err || m.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_op%0d: rdata=%h err=%b req_ready=%b, need rdata=%h err=%b req_ready=0",
                 cur.id, m.rsp_rdata, m.rsp_err, m.req_ready, seen_rd, seen_err);
      end
      if (hold_left > 0) begin
        m.rsp_ready = 1'b0;
        hold_left--;
      end else begin
        m.rsp_ready = ($urandom_range(0, 2) != 0);
      end
      if (m.rsp_ready) busy = 1'b0;
    end else begin
      if (busy) begin
        n_tests++; n_fail++;
        $display("FAIL drop_op%0d: rsp_valid=0 before rsp_ready, need 1", cur.id);
        busy = 1'b0;
      end
      m.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic b_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, output logic [31:0] rd, output int lat);
    int unsigned start;
    int          guard;
    rd  = 'x;
    lat = -1;
    @(negedge clk);
    b.req_valid = 1'b1; b.req_wr = wr; b.req_addr = addr; b.req_wdata = wdata; b.req_func3 = f3;
    guard = 0;
    while (b.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start = cyc;
    @(posedge clk);
    #1 b.req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b.rsp_valid === 1'b1) begin
        lat = int'(cyc - start);
        rd  = b.rsp_rdata;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running, need finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          lat, guard;
    logic        seen;

    rst_n = 1'b0; rst_n_b = 1'b0;
    m.req_valid = 1'b0; m.req_wr = 1'b0; m.req_addr = '0; m.req_wdata = '0; m.req_func3 = '0;
    b.req_valid = 1'b0; b.req_wr = 1'b0; b.req_addr = '0; b.req_wdata = '0; b.req_func3 = '0;
    b.rsp_ready = 1'b1;
    #22;
    chk("rst_rsp_valid", 32'(m.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", m.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(m.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rst_n_b = 1'b1;
    #1 chk("rst_req_ready", 32'(m.req_ready), 32'd1);

    for (int w = 0; w < 16; w++) issue(1'b1, 32'(w * 4), $urandom, 3'd2, 0);

    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, 0);
    issue(1'b0, 32'h10, 32'h0, 3'd2, 0);
    issue(1'b1, 32'h10, 32'h80FF_7F01, 3'd2, 0);
    issue(1'b0, 32'h11, 32'h0, 3'd0, 0);
    issue(1'b0, 32'h12, 32'h0, 3'd0, 0);
    issue(1'b0, 32'h13, 32'h0, 3'd4, 0);
    issue(1'b0, 32'h12, 32'h0, 3'd1, 0);
    issue(1'b0, 32'h12, 32'h0, 3'd5, 0);
    issue(1'b1, 32'h10, 32'h1122_3344, 3'd2, 0);
    issue(1'b1, 32'h12, 32'h0000_00AA, 3'd0, 5);
    issue(1'b0, 32'h10, 32'h0, 3'd2, 0);
    issue(1'b0, 32'h12, 32'h0, 3'd2, 0);
    issue(1'b1, 32'h13, 32'h0000_BEEF, 3'd1, 0);
    issue(1'b0, 32'h10, 32'h0, 3'd2, 0);
    issue(1'b1, 32'h1000, 32'h5A5A_5A5A, 3'd2, 0);
    issue(1'b0, 32'h0, 32'h0, 3'd2, 0);

    for (int i = 0; i < 200; i++) begin
      issue(1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
            $urandom, 3'($urandom_range(0, 7)), 0);
    end

    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_outstanding", 32'(sb.size()), 32'd0);

    b_access(1'b1, 32'h20, 32'h0, 3'd2, rd, lat);
    chk("b_sw_latency", 32'(lat), 32'(WAIT_B + 1));
    b_access(1'b1, 32'h24, 32'hCAFE_F00D, 3'd2, rd, lat);
    b_access(0, 32'h26, 32'h0, 3'd1, rd, lat);
    chk("b_lh_rdata", rd, 32'hFFFF_CAFE);
    chk("b_lh_latency", 32'(lat), 32'(WAIT_B + 1));

    @(negedge clk);
    b.req_valid = 1'b1; b.req_wr = 1'b1; b.req_addr = 32'h20;
    b.req_wdata = 32'h1234_5678; b.req_func3 = 3'd2;
    guard = 0;
    while (b.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 b.req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n_b = 1'b0;
    #1 chk("b_abort_rsp_valid", 32'(b.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n_b = 1'b1;
    #1 chk("b_abort_req_ready", 32'(b.req_ready), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (b.rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("b_abort_no_rsp", 32'(seen), 32'd0);
    b_access(1'b0, 32'h20, 32'h0, 3'd2, rd, lat);
    chk("b_abort_no_store", rd, 32'd0);
    chk("b_lw_latency", 32'(lat), 32'(WAIT_B + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/r200dmem_resp.md
R200DMEM_RESP -- requirements
Module: r200dmem_resp

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 1, meaning wait-state cycles between request acceptance and the response (legal range 0..15).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning log2 of the storage depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  the CPU presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  the responder accepts the request this cycle.
REQ-007 SHALL have port req_wr  input  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_func3  input  3  RV32I funct3 size/sign code.
REQ-011 SHALL have port rsp_valid  output  1  the response is present.
REQ-012 SHALL have port rsp_ready  input  1  the CPU accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended per func3; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  misaligned or illegal access, qualified by rsp_valid.

Function
REQ-015 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-016 SHALL capture req_wr, req_addr, req_wdata and req_func3 on the handshake req_valid&req_ready, then move to WAIT, or to RESP directly when WAIT_CYC=0.
REQ-017 SHALL count WAIT_CYC cycles in WAIT with a 4-bit down-counter and enter RESP when it reaches 0; latency from acceptance to the first rsp_valid cycle is WAIT_CYC+1 cycles.
REQ-018 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on the next edge; there is no back-to-back bypass.
REQ-019 SHALL index the word address as addr[ADDR_W+1:2] and ignore the upper address bits, so addresses wrap modulo 4*2^ADDR_W bytes.
REQ-020 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU, selecting the byte or halfword by addr[1:0]; LB/LH sign-extend and LBU/LHU zero-extend.
REQ-021 SHALL decode stores as 000 SB, 001 SH and 010 SW, using per-byte write enables so that untouched bytes are preserved.
REQ-022 SHALL commit a store exactly once, on the edge entering RESP; it SHALL NOT re-commit while RESP is held by rsp_ready=0.
REQ-023 SHALL sample load data on the edge entering RESP; a store committed earlier is visible to a subsequent load.
REQ-024 SHALL ignore req_valid outside IDLE; the requester holds its request until req_ready.
REQ-025 SHALL zero rsp_rdata for stores and for any access with rsp_err=1.

Reset
REQ-026 SHALL, on rst_n=0 and regardless of clk, force state IDLE, the counter to 0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, with req_ready=1 once rst_n is released.
REQ-027 SHALL, on reset during WAIT, abort the access with no store committed; on reset during RESP, drop the response.
REQ-028 SHALL NOT reset the storage array; its contents are undefined after power-up.

Configuration
REQ-029 SHALL, with macro R200_DMEM_ALIGN_CHK_EN defined, set rsp_err=1 with no write for: a misaligned LH/LHU/SH (addr[0]=1); a misaligned LW/SW (addr[1:0]!=0); an illegal func3 (loads 011/110/111, stores other than 000/001/010).
REQ-030 SHALL, without R200_DMEM_ALIGN_CHK_EN, tie rsp_err to 0, force the offending low address bits to 0 (natural alignment), and treat an illegal func3 as LW/SW.

Verification
REQ-031 SHALL cover: WAIT_CYC=1, SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after each acceptance.
REQ-032 SHALL cover: memory word 0x10=0x80FF7F01, then LB 0x11 -> 0x0000007F, LB 0x12 -> 0xFFFFFFFF, LBU 0x13 -> 0x00000080, LH 0x12 -> 0xFFFF80FF, LHU 0x12 -> 0x000080FF.
REQ-033 SHALL cover: SB 0x12 data 0x000000AA onto 0x11223344 -> LW 0x10 returns 0x11AA3344; hold rsp_ready=0 for 5 cycles -> exactly one write, outputs stable, req_ready=0 throughout.
REQ-034 SHALL cover: with ALIGN_CHK_EN, LW 0x12 -> rsp_err=1, rdata=0; SH 0x13 -> rsp_err=1, memory unchanged; without ALIGN_CHK_EN, LW 0x12 returns the word at 0x10, rsp_err=0.
REQ-035 SHALL cover: ADDR_W=10, SW addr 0x1000 data 0x5A5A5A5A -> LW addr 0x0 returns 0x5A5A5A5A (wrap).
REQ-036 SHALL cover: WAIT_CYC=3, rst_n pulsed low 1 cycle after accepting SW 0x20 data 0x12345678 (word previously 0) -> rsp_valid=0 immediately, next LW 0x20 returns 0.
